// File: rtl/mlp_pkg.sv
// Shared configuration, FSM state type and fixed-point helpers for the
// time-multiplexed MLP layer engine.
package mlp_pkg;

  localparam int WORD_SIZE = 8;
  localparam int FRAC_BITS = 4;
  localparam int N         = 4;
  localparam int L         = 3;
  localparam logic [L-1:0] ACT_MASK = 3'b011;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n + 1) + 1;
  endfunction

  localparam int ACC_W   = acc_width(WORD_SIZE, N);
  localparam int ADDR_W  = $clog2(L * (N + 1));
  localparam int LAYER_W = $clog2(L) + 1;
  localparam int K_W     = $clog2(N + 1);
  localparam int VEC_W   = N * WORD_SIZE;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (WORD_SIZE - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WB    = 3'd3,
    OUT   = 3'd4
  } mlp_state_t;

  // Floor shift back to WORD_SIZE scale, optional ReLU, then clamp.
  function automatic logic signed [WORD_SIZE-1:0] sat_act(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (relu && sh[ACC_W-1]) sh = '0;
    if (sh > SAT_MAX) sh = SAT_MAX;
    else if (sh < SAT_MIN) sh = SAT_MIN;
    return sh[WORD_SIZE-1:0];
  endfunction

endpackage

// File: rtl/mlp_layer_engine_if.sv
// Input, output and weight-memory bus of the MLP engine; slave = engine side.
interface mlp_layer_engine_if;
  import mlp_pkg::*;

  // A transfer happens on a rising edge where valid and ready are both high;
  // the source holds valid and data stable until that edge.
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  in_data;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [VEC_W-1:0]  w_data;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data
  );

endinterface

// File: rtl/mlp_mac_lane.sv
// One neuron: accumulates activation*weight products plus the bias row and
// presents the activated, saturated result for write-back.
module mlp_mac_lane
  import mlp_pkg::*;
(
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        clr,
  input  logic                        acc_en,
  input  logic                        is_bias,
  input  logic signed [WORD_SIZE-1:0] a,
  input  logic signed [WORD_SIZE-1:0] w,
  input  logic                        relu,
  output logic signed [WORD_SIZE-1:0] y
);

  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       prod_ext;
  logic signed [ACC_W-1:0]       bias_ext;

  assign prod     = a * w;
  assign prod_ext = {{(ACC_W - 2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
  // Bias is scaled by 1.0 so it lines up with the product's binary point.
  assign bias_ext = {{(ACC_W - WORD_SIZE - FRAC_BITS){w[WORD_SIZE-1]}}, w, {FRAC_BITS{1'b0}}};

  always_comb begin
    acc_d = acc_q;
    if (clr) acc_d = '0;
    else if (acc_en) acc_d = acc_q + (is_bias ? bias_ext : prod_ext);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign y = sat_act(acc_q, relu);

endmodule

// File: rtl/mlp_layer_engine.sv
// Runs L fully connected layers back-to-back over one activation buffer,
// streaming one weight row per cycle from a synchronous external memory.
module mlp_layer_engine
  import mlp_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               flush,
  mlp_layer_engine_if.slave  bus,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_idx,
  output mlp_state_t         dbg_state
);

  mlp_state_t         state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [K_W-1:0]     kd_q, kd_d;
  logic               rd_q, rd_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] act_q [N];
  logic [WORD_SIZE-1:0] act_d [N];

  logic                 lane_clr;
  logic                 lane_bias;
  logic                 lane_relu;
  logic [WORD_SIZE-1:0] lane_a;
  logic [WORD_SIZE-1:0] lane_y [N];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    layer_d     = layer_q;
    act_d       = act_q;
    out_valid_d = 1'b0;
    lane_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int j = 0; j < N; j++) act_d[j] = bus.in_data[j*WORD_SIZE +: WORD_SIZE];
          layer_d  = '0;
          k_d      = '0;
          lane_clr = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (k_q == K_W'(N)) state_d = DRAIN;
        else                k_d     = k_q + 1'b1;
      end
      DRAIN: state_d = WB;
      WB: begin
        for (int j = 0; j < N; j++) act_d[j] = lane_y[j];
        lane_clr = 1'b1;
        layer_d  = layer_q + 1'b1;
        k_d      = '0;
        state_d  = (layer_q == LAYER_W'(L - 1)) ? OUT : RUN;
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) state_d     = IDLE;
        else                              out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      k_d         = '0;
      layer_d     = '0;
      out_valid_d = 1'b0;
      lane_clr    = 1'b1;
    end
    // Memory strobe/address are registered: they describe the row the next cycle reads.
    w_rd_en_d = (state_d == RUN);
    w_addr_d  = w_rd_en_d ? ADDR_W'(32'(layer_d) * (N + 1) + 32'(k_d)) : '0;
    rd_d      = w_rd_en_q && !flush;
    kd_d      = k_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      kd_q        <= '0;
      rd_q        <= 1'b0;
      layer_q     <= '0;
      w_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < N; j++) act_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      kd_q        <= kd_d;
      rd_q        <= rd_d;
      layer_q     <= layer_d;
      w_rd_en_q   <= w_rd_en_d;
      w_addr_q    <= w_addr_d;
      out_valid_q <= out_valid_d;
      act_q       <= act_d;
    end
  end

  // Row data arrives one cycle after the read, so select with the delayed row index.
  always_comb begin
    lane_a = '0;
    for (int i = 0; i < N; i++) begin
      if (kd_q == K_W'(i)) lane_a = act_q[i];
    end
  end

  always_comb begin
    lane_relu = 1'b0;
    for (int l = 0; l < L; l++) begin
      if (layer_q == LAYER_W'(l)) lane_relu = ACT_MASK[l];
    end
  end

  assign lane_bias = (kd_q == K_W'(N));

  for (genvar j = 0; j < N; j++) begin : g_lane
    mlp_mac_lane u_lane (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr     (lane_clr),
      .acc_en  (rd_q),
      .is_bias (lane_bias),
      .a       (lane_a),
      .w       (bus.w_data[j*WORD_SIZE +: WORD_SIZE]),
      .relu    (lane_relu),
      .y       (lane_y[j])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid_q) bus.out_data[j*WORD_SIZE +: WORD_SIZE] = act_q[j];
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.w_rd_en   = w_rd_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN) || (state_q == WB);
  assign layer_idx     = layer_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Self-checking bench for mlp_layer_engine: directed fixed-point cases plus
// randomized vectors scored against an integer-arithmetic reference network.
module tb_mlp_layer_engine;
  import mlp_pkg::*;

  localparam int ONE    = 16;
  localparam int SMAX   = 127;
  localparam int SMIN   = -128;
  localparam int LAT    = 22;
  localparam int NROWS  = 15;
  localparam logic [2:0] RELU_LAYERS = 3'b011;

  logic               clk = 1'b0;
  logic               n_rst = 1'b0;
  logic               flush = 1'b0;
  logic               busy;
  logic [LAYER_W-1:0] layer_idx;
  mlp_state_t         dbg_state;

  mlp_layer_engine_if bus ();

  mlp_layer_engine u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .layer_idx (layer_idx),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int wt [3][5][4];
  logic [31:0] wmem [NROWS];
  logic [3:0]  addr_log [$];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
  always @(negedge clk) if (bus.w_rd_en) addr_log.push_back(bus.w_addr);

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_net(input logic [31:0] vin);
    int x [4];
    int y [4];
    int s, q;
    logic signed [7:0] b;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      b = vin[j*8 +: 8];
      x[j] = b;
    end
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 4; j++) begin
        s = wt[l][4][j] * ONE;
        for (int k = 0; k < 4; k++) s += x[k] * wt[l][k][j];
        q = s / ONE;
        if ((s % ONE) != 0 && s < 0) q = q - 1;
        if (RELU_LAYERS[l] && q < 0) q = 0;
        if (q > SMAX) q = SMAX;
        if (q < SMIN) q = SMIN;
        y[j] = q;
      end
      x = y;
    end
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(x[j]);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_mem();
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 5; k++)
        for (int j = 0; j < 4; j++)
          wmem[l*5 + k][j*8 +: 8] = 8'(wt[l][k][j]);
  endtask

  task automatic set_diag(input int d0, input int d1, input int d2);
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 5; k++)
        for (int j = 0; j < 4; j++)
          wt[l][k][j] = (k == j) ? ((l == 0) ? d0 : (l == 1) ? d1 : d2) : 0;
    load_mem();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_vec(input logic [31:0] v);
    chk("in_ready_pre", bus.in_ready, 1'b1);
    addr_log.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [31:0] v, input int stall, output logic [31:0] got);
    int cyc;
    logic [31:0] held;
    logic [31:0] exp;
    exp_q.push_back(ref_net(v));
    start_vec(v);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", cyc, LAT);
    if (cyc >= 200) begin
      exp = exp_q.pop_front();
      got = '0;
      return;
    end
    chk("addr_count", addr_log.size(), NROWS);
    for (int i = 0; i < addr_log.size() && i < NROWS; i++) chk("w_addr_seq", addr_log[i], i);
    chk("in_ready_out", bus.in_ready, 1'b0);
    held = bus.out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data", bus.out_data, held);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 1'b0);
    chk("in_ready_after", bus.in_ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    exp = exp_q.pop_front();
    chk("out_data", held, exp);
    got = held;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] v;
    int wb_seen, guard, span;

    do_reset();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_w_rd_en", bus.w_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_w_addr", bus.w_addr, 4'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_layer_idx", layer_idx, 3'd0);

    set_diag(16, 16, 16);
    run_vec(32'h04081020, 0, got);
    chk("ident_const", got, 32'h04081020);
    run_vec(32'h040810F0, 1, got);
    chk("relu_lane0", got, 32'h04081000);

    set_diag(127, 127, 127);
    run_vec(32'h40404040, 0, got);
    chk("sat_pos", got, 32'h7F7F7F7F);
    run_vec(32'hC0C0C0C0, 0, got);
    chk("relu_neg", got, 32'h00000000);
    set_diag(16, 16, -127);
    run_vec(32'h40404040, 0, got);
    chk("sat_neg_ident", got, 32'h80808080);

    set_diag(0, 0, 0);
    for (int j = 0; j < 4; j++) wt[2][4][j] = -32;
    load_mem();
    run_vec(32'h5A3C7F81, 0, got);
    chk("bias_only", got, 32'hE0E0E0E0);

    set_diag(16, 16, 16);
    run_vec(32'h11223344, 5, got);
    chk("bp_first", got, 32'h11223344);
    run_vec(32'h7F010203, 0, got);
    chk("bp_second", got, 32'h7F010203);

    // async reset in the middle of layer 1
    start_vec(32'h33333333);
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_w_rd_en", bus.w_rd_en, 1'b0);
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_layer_idx", layer_idx, 3'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // flush during the write-back of layer 1
    start_vec(32'h22222222);
    wb_seen = 0;
    guard = 0;
    while (wb_seen < 2 && guard < 100) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (dbg_state == WB) wb_seen++;
    end
    chk("wb_reached", wb_seen, 2);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_busy", busy, 1'b0);
    chk("flush_w_rd_en", bus.w_rd_en, 1'b0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    repeat (30) @(negedge clk);
    chk("flush_no_result", bus.out_valid, 1'b0);

    set_diag(16, 32, 8);
    for (int j = 0; j < 4; j++) wt[1][4][j] = j - 2;
    load_mem();
    run_vec(32'h10F00C30, 0, got);

    for (int r = 0; r < 8; r++) begin
      span = (r % 2 == 1) ? 127 : 24;
      for (int l = 0; l < 3; l++)
        for (int k = 0; k < 5; k++)
          for (int j = 0; j < 4; j++)
            wt[l][k][j] = int'($urandom_range(0, 2 * span)) - span;
      load_mem();
      v = $urandom;
      run_vec(v, int'($urandom_range(0, 3)), got);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
